// File: rtl/fetch_unit_fq_if.sv
// Fetch unit bus bundle: the I$ request/response pair and the
// valid/ready handshake toward decode. The fetch unit is the master.
interface fetch_unit_fq_if #(
  parameter int PC_WIDTH = 14
);
  // I$ side
  logic                icache_hit;
  logic [31:0]         icache_load;
  logic                icache_REN;
  logic [31:0]         icache_addr;
  logic                icache_halt;

  // Decode side
  logic                to_pipeline_valid;
  logic                to_pipeline_ready;
  logic [31:0]         to_pipeline_instr;
  logic [PC_WIDTH-1:0] to_pipeline_PC;
  logic [PC_WIDTH-1:0] to_pipeline_nPC;

  modport master (
    input  icache_hit, icache_load, to_pipeline_ready,
    output icache_REN, icache_addr, icache_halt,
           to_pipeline_valid, to_pipeline_instr, to_pipeline_PC, to_pipeline_nPC
  );

  modport slave (
    output icache_hit, icache_load, to_pipeline_ready,
    input  icache_REN, icache_addr, icache_halt,
           to_pipeline_valid, to_pipeline_instr, to_pipeline_PC, to_pipeline_nPC
  );
endinterface

// File: rtl/fetch_unit_fq.sv
// Fetch unit with tagged BTB + saturating direction counters, a bounded
// return-address stack and a fetch queue decoupling I$ from decode.
// Instruction pre-decode follows the MIPS opcode map (BEQ/BNE/J/JAL/JR).
module fetch_unit_fq #(
  parameter int          PC_WIDTH      = 14,
  parameter logic [31:0] PC_RESET_VAL  = 32'h0,
  parameter int          BTB_ENTRIES   = 8,
  parameter int          BTB_TAG_WIDTH = 4,
  parameter int          DIRP_BITS     = 2,
  parameter int          RAS_DEPTH     = 4,
  parameter int          FQ_DEPTH      = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       from_pipeline_BTB_DIRP_update,
  input  logic [PC_WIDTH-1:0]        from_pipeline_BTB_DIRP_PC,
  input  logic [PC_WIDTH-1:0]        from_pipeline_BTB_target,
  input  logic                       from_pipeline_DIRP_taken,
  input  logic                       from_pipeline_take_resolved,
  input  logic [PC_WIDTH-1:0]        from_pipeline_resolved_PC,
  input  logic                       core_control_halt,
  fetch_unit_fq_if.master            bus,
  output logic [$clog2(FQ_DEPTH):0]  fq_count
);

  localparam int IDX_W  = $clog2(BTB_ENTRIES);
  localparam int RAS_PW = $clog2(RAS_DEPTH);
  localparam int FQ_PW  = $clog2(FQ_DEPTH);

  localparam logic [PC_WIDTH-1:0]  PC_RESET    = PC_RESET_VAL[PC_WIDTH+1:2];
  localparam logic [DIRP_BITS-1:0] CTR_MAX     = '1;
  localparam logic [DIRP_BITS-1:0] CTR_WEAK_T  = DIRP_BITS'(1) << (DIRP_BITS - 1);
  localparam logic [DIRP_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - DIRP_BITS'(1);
  localparam logic [RAS_PW:0]      RAS_FULL    = (RAS_PW + 1)'(RAS_DEPTH);
  localparam logic [FQ_PW:0]       FQ_FULL     = (FQ_PW + 1)'(FQ_DEPTH);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FN_JR      = 6'h08;

  typedef enum logic [2:0] {IC_OTHER, IC_BRANCH, IC_JUMP, IC_JAL, IC_JR} instr_class_e;

  // Fetch PC and registered I$ controls
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                icache_ren_q, icache_halt_q;

  // Fetch queue
  logic [31:0]         fq_instr_q [FQ_DEPTH];
  logic [PC_WIDTH-1:0] fq_pc_q    [FQ_DEPTH];
  logic [PC_WIDTH-1:0] fq_npc_q   [FQ_DEPTH];
  logic [FQ_PW-1:0]    fq_head_q, fq_head_d, fq_tail_q, fq_tail_d;
  logic [FQ_PW:0]      fq_count_q, fq_count_d;
  logic                fq_valid, fq_full;

  // Return address stack
  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [RAS_PW-1:0]   ras_ptr_q, ras_ptr_d;
  logic [RAS_PW:0]     ras_count_q, ras_count_d;
  logic                ras_push, ras_pop;
  logic [PC_WIDTH-1:0] ras_top;

  // BTB + direction counters
  logic                     btb_valid_q [BTB_ENTRIES];
  logic [BTB_TAG_WIDTH-1:0] btb_tag_q   [BTB_ENTRIES];
  logic [PC_WIDTH-1:0]      btb_tgt_q   [BTB_ENTRIES];
  logic [DIRP_BITS-1:0]     btb_ctr_q   [BTB_ENTRIES];

  logic [IDX_W-1:0]         lk_idx, up_idx;
  logic [BTB_TAG_WIDTH-1:0] lk_tag, up_tag;
  logic                     lk_hit, up_hit;
  logic [DIRP_BITS-1:0]     up_ctr_d;

  instr_class_e        iclass;
  logic [PC_WIDTH-1:0] pc_plus1, pred_npc;
  logic                accept, deq, flush;

  // Instruction bits outside the opcode/funct/target fields and PC bits above
  // the BTB tag play no part in prediction.
  logic unused_bits;
  assign unused_bits = ^{bus.icache_load[25:PC_WIDTH],
                         from_pipeline_BTB_DIRP_PC[PC_WIDTH-1:IDX_W+BTB_TAG_WIDTH]};

  assign flush    = from_pipeline_take_resolved;
  assign fq_valid = (fq_count_q != '0);
  assign fq_full  = (fq_count_q == FQ_FULL);
  assign accept   = bus.icache_hit & ~fq_full & ~flush & ~core_control_halt;
  assign deq      = fq_valid & bus.to_pipeline_ready & ~flush;

  assign pc_plus1 = pc_q + PC_WIDTH'(1);
  assign lk_idx   = pc_q[IDX_W-1:0];
  assign lk_tag   = pc_q[IDX_W +: BTB_TAG_WIDTH];
  assign lk_hit   = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
  assign ras_top  = ras_q[ras_ptr_q - RAS_PW'(1)];

  // Pre-decode the fetched word into a control-flow class
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    iclass = IC_OTHER;
    case (bus.icache_load[31:26])
      OP_BEQ, OP_BNE: iclass = IC_BRANCH;
      OP_J:           iclass = IC_JUMP;
      OP_JAL:         iclass = IC_JAL;
      OP_SPECIAL:     if (bus.icache_load[5:0] == FN_JR) iclass = IC_JR;
      default:        iclass = IC_OTHER;
    endcase
  end

  // Predicted next PC for the word being fetched
  always_comb begin
    pred_npc = pc_plus1;
    case (iclass)
      IC_BRANCH: if (lk_hit && btb_ctr_q[lk_idx][DIRP_BITS-1]) pred_npc = btb_tgt_q[lk_idx];
      IC_JUMP,
      IC_JAL:    pred_npc = bus.icache_load[PC_WIDTH-1:0];
      IC_JR:     if (ras_count_q != '0) pred_npc = ras_top;
      default:   pred_npc = pc_plus1;
    endcase
  end

  // Next PC, fetch-queue pointers/occupancy and RAS pointer/occupancy
  always_comb begin
    pc_d        = pc_q;
    fq_head_d   = fq_head_q;
    fq_tail_d   = fq_tail_q;
    fq_count_d  = fq_count_q;
    ras_push    = accept && (iclass == IC_JAL);
    ras_pop     = accept && (iclass == IC_JR) && (ras_count_q != '0);
    ras_ptr_d   = ras_ptr_q;
    ras_count_d = ras_count_q;

    if (flush)       pc_d = from_pipeline_resolved_PC;
    else if (accept) pc_d = pred_npc;

    if (flush) begin
      fq_head_d  = '0;
      fq_tail_d  = '0;
      fq_count_d = '0;
    end else begin
      if (accept) fq_tail_d = fq_tail_q + FQ_PW'(1);
      if (deq)    fq_head_d = fq_head_q + FQ_PW'(1);
      case ({accept, deq})
        2'b10:   fq_count_d = fq_count_q + (FQ_PW + 1)'(1);
        2'b01:   fq_count_d = fq_count_q - (FQ_PW + 1)'(1);
        default: fq_count_d = fq_count_q;
      endcase
    end

    // A full RAS keeps pushing: the write wraps over the oldest entry.
    if (ras_push) begin
      ras_ptr_d = ras_ptr_q + RAS_PW'(1);
      if (ras_count_q != RAS_FULL) ras_count_d = ras_count_q + (RAS_PW + 1)'(1);
    end else if (ras_pop) begin
      ras_ptr_d   = ras_ptr_q - RAS_PW'(1);
      ras_count_d = ras_count_q - (RAS_PW + 1)'(1);
    end
  end

  // BTB update: train on a tag hit, allocate at weak strength on a miss
  always_comb begin
    up_idx   = from_pipeline_BTB_DIRP_PC[IDX_W-1:0];
    up_tag   = from_pipeline_BTB_DIRP_PC[IDX_W +: BTB_TAG_WIDTH];
    up_hit   = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
    up_ctr_d = from_pipeline_DIRP_taken ? CTR_WEAK_T : CTR_WEAK_NT;
    if (up_hit) begin
      up_ctr_d = btb_ctr_q[up_idx];
      if (from_pipeline_DIRP_taken) begin
        if (btb_ctr_q[up_idx] != CTR_MAX) up_ctr_d = btb_ctr_q[up_idx] + DIRP_BITS'(1);
      end else begin
        if (btb_ctr_q[up_idx] != '0)      up_ctr_d = btb_ctr_q[up_idx] - DIRP_BITS'(1);
      end
    end
  end

  // PC and registered I$ controls
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q          <= PC_RESET;
      icache_ren_q  <= 1'b0;
      icache_halt_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      icache_ren_q  <= ~core_control_halt;
      icache_halt_q <= core_control_halt;
    end
  end

  // Fetch-queue pointers and occupancy
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fq_head_q  <= '0;
      fq_tail_q  <= '0;
      fq_count_q <= '0;
    end else begin
      fq_head_q  <= fq_head_d;
      fq_tail_q  <= fq_tail_d;
      fq_count_q <= fq_count_d;
    end
  end

  // Fetch-queue storage, written at the tail on accept
  // NOTE: storage is not reset; the head outputs are forced to zero while the queue is empty.
  always_ff @(posedge CLK) begin
    if (accept) begin
      fq_instr_q[fq_tail_q] <= bus.icache_load;
      fq_pc_q[fq_tail_q]    <= pc_q;
      fq_npc_q[fq_tail_q]   <= pred_npc;
    end
  end

  // Return address stack
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ras_ptr_q   <= '0;
      ras_count_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      ras_ptr_q   <= ras_ptr_d;
      ras_count_q <= ras_count_d;
      if (ras_push) ras_q[ras_ptr_q] <= pc_plus1;
    end
  end

  // BTB and direction counters; the write lands after this cycle's lookup
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
        btb_ctr_q[i]   <= CTR_WEAK_NT;
      end
    end else if (from_pipeline_BTB_DIRP_update) begin
      btb_valid_q[up_idx] <= 1'b1;
      btb_tag_q[up_idx]   <= up_tag;
      btb_tgt_q[up_idx]   <= from_pipeline_BTB_target;
      btb_ctr_q[up_idx]   <= up_ctr_d;
    end
  end

  assign bus.icache_REN        = icache_ren_q;
  assign bus.icache_halt       = icache_halt_q;
  assign bus.icache_addr       = 32'({pc_q, 2'b00});
  assign bus.to_pipeline_valid = fq_valid;
  assign bus.to_pipeline_instr = fq_valid ? fq_instr_q[fq_head_q] : '0;
  assign bus.to_pipeline_PC    = fq_valid ? fq_pc_q[fq_head_q]    : '0;
  assign bus.to_pipeline_nPC   = fq_valid ? fq_npc_q[fq_head_q]   : '0;
  assign fq_count              = fq_count_q;

endmodule

// File: tb/tb_fetch_unit_fq.sv
// Scoreboard bench for fetch_unit_fq: stimulus pushes the expected
// {instr, PC, nPC} of every accepted fetch; a negedge monitor pops and
// compares whenever decode takes the queue head.
module tb_fetch_unit_fq;
  localparam int PC_W = 14;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] npc;
  } exp_t;

  localparam logic [31:0] JR_RA = 32'h03E0_0008;
  localparam logic [31:0] BEQ_I = 32'h1000_0005;
  localparam logic [31:0] BNE_I = 32'h1400_0003;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic            upd = 1'b0, upd_taken = 1'b0, take = 1'b0, halt = 1'b0;
  logic [PC_W-1:0] upd_pc = '0, upd_tgt = '0, res_pc = '0;
  logic [2:0]      fq_count;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_unit_fq_if #(.PC_WIDTH(PC_W)) bus ();

  fetch_unit_fq #(
    .PC_WIDTH(PC_W), .PC_RESET_VAL(32'h0), .BTB_ENTRIES(8), .BTB_TAG_WIDTH(4),
    .DIRP_BITS(2), .RAS_DEPTH(4), .FQ_DEPTH(4)
  ) dut (
    .CLK                          (CLK),
    .nRST                         (nRST),
    .from_pipeline_BTB_DIRP_update(upd),
    .from_pipeline_BTB_DIRP_PC    (upd_pc),
    .from_pipeline_BTB_target     (upd_tgt),
    .from_pipeline_DIRP_taken     (upd_taken),
    .from_pipeline_take_resolved  (take),
    .from_pipeline_resolved_PC    (res_pc),
    .core_control_halt            (halt),
    .bus                          (bus),
    .fq_count                     (fq_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare the queue head each time decode takes it
  always @(negedge CLK) begin
    exp_t e;
    if (nRST && !take && bus.to_pipeline_valid && bus.to_pipeline_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_head: got PC 0x%0h, expected no entry", bus.to_pipeline_PC);
      end else begin
        e = exp_q.pop_front();
        check("head_instr", 64'(bus.to_pipeline_instr), 64'(e.instr));
        check("head_pc",    64'(bus.to_pipeline_PC),    64'(e.pc));
        check("head_npc",   64'(bus.to_pipeline_nPC),   64'(e.npc));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [PC_W-1:0] pc,
                          input logic [PC_W-1:0] npc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.npc   = npc;
    exp_q.push_back(e);
  endtask

  // One accepted fetch at the expected PC
  task automatic fetch(input logic [31:0] instr, input logic [PC_W-1:0] pc,
                       input logic [PC_W-1:0] npc);
    check("icache_addr", 64'(bus.icache_addr), 64'({pc, 2'b00}));
    bus.icache_hit  = 1'b1;
    bus.icache_load = instr;
    push_exp(instr, pc, npc);
    step();
    bus.icache_hit  = 1'b0;
  endtask

  task automatic redirect(input logic [PC_W-1:0] pc);
    take   = 1'b1;
    res_pc = pc;
    exp_q.delete();
    step();
    take   = 1'b0;
  endtask

  task automatic btb_upd(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt, input logic tkn);
    upd = 1'b1; upd_pc = pc; upd_tgt = tgt; upd_taken = tkn;
    step();
    upd = 1'b0;
  endtask

  task automatic drain();
    bus.to_pipeline_ready = 1'b1;
    bus.icache_hit        = 1'b0;
    for (int i = 0; i < 20 && fq_count != 0; i++) step();
    check("drain_count", 64'(fq_count), 64'd0);
  endtask

  // Asynchronous reset away from the clock edge, then check reset state
  task automatic do_reset();
    nRST = 1'b0;
    exp_q.delete();
    bus.icache_hit = 1'b0; bus.icache_load = '0; bus.to_pipeline_ready = 1'b0;
    upd = 1'b0; take = 1'b0; halt = 1'b0;
    #2;
    check("rst_ren",   64'(bus.icache_REN),        64'd0);
    check("rst_halt",  64'(bus.icache_halt),       64'd0);
    check("rst_valid", 64'(bus.to_pipeline_valid), 64'd0);
    check("rst_count", 64'(fq_count),              64'd0);
    check("rst_addr",  64'(bus.icache_addr),       64'd0);
    check("rst_instr", 64'(bus.to_pipeline_instr), 64'd0);
    check("rst_pc",    64'(bus.to_pipeline_PC),    64'd0);
    check("rst_npc",   64'(bus.to_pipeline_nPC),   64'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    step();
    check("ren_after_rst", 64'(bus.icache_REN), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.icache_hit = 1'b0; bus.icache_load = '0; bus.to_pipeline_ready = 1'b0;

    // Sequential non-branch fetch with decode always ready
    do_reset();
    bus.to_pipeline_ready = 1'b1;
    check("valid_before_hit", 64'(bus.to_pipeline_valid), 64'd0);
    fetch(32'h2000_0000, 14'h0, 14'h1);
    check("valid_after_hit", 64'(bus.to_pipeline_valid), 64'd1);
    for (int k = 1; k < 6; k++) fetch(32'h2000_0000 | 32'(k), 14'(k), 14'(k + 1));
    drain();

    // Mid-operation reset, then fill the queue with decode stalled
    do_reset();
    for (int k = 0; k < 4; k++) fetch(32'h2000_0100 | 32'(k), 14'(k), 14'(k + 1));
    check("fq_full_count", 64'(fq_count), 64'd4);
    bus.icache_hit  = 1'b1;
    bus.icache_load = 32'h2000_01FF;
    step();
    step();
    bus.icache_hit  = 1'b0;
    check("full_count_hold", 64'(fq_count), 64'd4);
    check("full_pc_hold", 64'(bus.icache_addr), 64'h10);
    bus.to_pipeline_ready = 1'b1;
    step();
    bus.to_pipeline_ready = 1'b0;
    check("one_deq_count", 64'(fq_count), 64'd3);
    fetch(32'h2000_0104, 14'h4, 14'h5);
    check("refill_count", 64'(fq_count), 64'd4);
    drain();

    // RAS: call/return, then overflow of a 4-deep stack
    do_reset();
    bus.to_pipeline_ready = 1'b1;
    redirect(14'h10);
    fetch(32'h0C00_0040, 14'h10, 14'h40);
    fetch(JR_RA,         14'h40, 14'h11);
    fetch(32'h0C00_0020, 14'h11, 14'h20);
    fetch(32'h0C00_0030, 14'h20, 14'h30);
    fetch(32'h0C00_0050, 14'h30, 14'h50);
    fetch(32'h0C00_0060, 14'h50, 14'h60);
    fetch(32'h0C00_0070, 14'h60, 14'h70);
    fetch(JR_RA, 14'h70, 14'h61);
    fetch(JR_RA, 14'h61, 14'h51);
    fetch(JR_RA, 14'h51, 14'h31);
    fetch(JR_RA, 14'h31, 14'h21);
    fetch(JR_RA, 14'h21, 14'h22);
    drain();

    // BTB allocate/train/saturate, same-cycle old-content lookup, tag mismatch
    do_reset();
    bus.to_pipeline_ready = 1'b1;
    redirect(14'h08);
    upd = 1'b1; upd_pc = 14'h08; upd_tgt = 14'h30; upd_taken = 1'b1;
    fetch(BEQ_I, 14'h08, 14'h09);
    upd = 1'b0;
    btb_upd(14'h08, 14'h30, 1'b1);
    btb_upd(14'h08, 14'h30, 1'b1);
    btb_upd(14'h08, 14'h30, 1'b0);
    redirect(14'h08);
    fetch(BEQ_I, 14'h08, 14'h30);
    redirect(14'h18);
    fetch(BNE_I, 14'h18, 14'h19);
    fetch(32'h0800_0200, 14'h19, 14'h200);
    btb_upd(14'h08, 14'h30, 1'b0);
    redirect(14'h08);
    fetch(BEQ_I, 14'h08, 14'h09);
    drain();

    // Flush with three queued entries
    bus.to_pipeline_ready = 1'b0;
    fetch(32'h2000_0200, 14'h09, 14'h0A);
    fetch(32'h2000_0201, 14'h0A, 14'h0B);
    fetch(32'h2000_0202, 14'h0B, 14'h0C);
    check("pre_flush_count", 64'(fq_count), 64'd3);
    take = 1'b1; res_pc = 14'h100;
    bus.icache_hit = 1'b1; bus.icache_load = 32'h2000_02FF; bus.to_pipeline_ready = 1'b1;
    exp_q.delete();
    step();
    take = 1'b0; bus.icache_hit = 1'b0; bus.to_pipeline_ready = 1'b0;
    check("flush_valid", 64'(bus.to_pipeline_valid), 64'd0);
    check("flush_count", 64'(fq_count), 64'd0);
    check("flush_addr",  64'(bus.icache_addr), 64'h400);

    // Halt: I$ controls flip next cycle, PC frozen, queue drains
    fetch(32'h2000_0300, 14'h100, 14'h101);
    fetch(32'h2000_0301, 14'h101, 14'h102);
    check("pre_halt_count", 64'(fq_count), 64'd2);
    halt = 1'b1;
    bus.icache_hit = 1'b1; bus.icache_load = 32'h2000_03FF;
    step();
    check("halt_ren",   64'(bus.icache_REN),  64'd0);
    check("halt_halt",  64'(bus.icache_halt), 64'd1);
    check("halt_count", 64'(fq_count),        64'd2);
    bus.to_pipeline_ready = 1'b1;
    step();
    step();
    step();
    check("halt_drained", 64'(fq_count),        64'd0);
    check("halt_pc_hold", 64'(bus.icache_addr), 64'h408);
    halt = 1'b0; bus.icache_hit = 1'b0; bus.to_pipeline_ready = 1'b0;
    step();
    check("unhalt_ren",  64'(bus.icache_REN),  64'd1);
    check("unhalt_halt", 64'(bus.icache_halt), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Reset with a non-empty queue
    fetch(32'h2000_0400, 14'h102, 14'h103);
    fetch(32'h2000_0401, 14'h103, 14'h104);
    check("pre_reset_count", 64'(fq_count), 64'd2);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit_fq.md
Name: fetch_unit_fq

Overview:
- Parametrised next-generation fetch unit: tagged BTB with N-bit saturating direction counters, bounded RAS with occupancy tracking, and an instruction fetch queue (FQ) decoupling I$ from decode via valid/ready.
- Sits between icache and the dispatch/decode stage in core; redirected by pipeline-resolved PC.

Parameters:
PC_WIDTH, 14, word-address PC width (byte addr = {PC,2'b00})
PC_RESET_VAL, 32'h0, byte reset address; PC resets to PC_RESET_VAL[PC_WIDTH+1:2]
BTB_ENTRIES, 8, BTB/DIRP entries (power of 2), index = PC[log2(BTB_ENTRIES)-1:0]
BTB_TAG_WIDTH, 4, tag = next PC bits above index
DIRP_BITS, 2, saturating counter width (>=1)
RAS_DEPTH, 4, RAS entries (power of 2)
FQ_DEPTH, 4, fetch queue entries (power of 2)

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
from_pipeline_BTB_DIRP_update  in  1  branch resolved, update BTB/DIRP
from_pipeline_BTB_DIRP_PC  in  PC_WIDTH  PC of resolved branch (index+tag source)
from_pipeline_BTB_target  in  PC_WIDTH  resolved taken target
from_pipeline_DIRP_taken  in  1  resolved direction
from_pipeline_take_resolved  in  1  redirect/flush
from_pipeline_resolved_PC  in  PC_WIDTH  redirect target
icache_hit  in  1  icache_load valid for icache_addr this cycle
icache_load  in  32  instruction word
icache_REN  out  1  read enable (registered)
icache_addr  out  32  {zeros, PC, 2'b00}
icache_halt  out  1  halt to I$ (registered)
core_control_halt  in  1  stop fetching
to_pipeline_valid  out  1  FQ head valid
to_pipeline_ready  in  1  decode accepts head
to_pipeline_instr  out  32  head instruction
to_pipeline_PC  out  PC_WIDTH  head PC
to_pipeline_nPC  out  PC_WIDTH  head predicted next PC
fq_count  out  log2(FQ_DEPTH)+1  current FQ occupancy

Behaviour:
- Reset: PC=reset value; icache_REN=0, icache_halt=0; FQ empty (valid=0, fq_count=0, head fields 0); RAS count=0, ptr=0, entries 0; all BTB valid=0, target/tag 0, counters = 2^(DIRP_BITS-1)-1 (weak NT).
- accept = icache_hit & ~full & ~take_resolved & ~core_control_halt. Only accept advances PC, enqueues {instr,PC,nPC}, updates RAS.
- nPC priority: take_resolved -> resolved_PC; accept -> prediction; else hold PC.
- Prediction (pre-decode of icache_load): BEQ/BNE -> BTB_target if BTB hit (valid & tag match) and counter MSB=1, else PC+1; J/JAL -> instr[PC_WIDTH-1:0]; JR -> RAS top if RAS count>0, else PC+1; other -> PC+1. PC+1 wraps modulo 2^PC_WIDTH.
- RAS (on accept only): JAL pushes PC+1 at ptr, ptr++, count=min(count+1,RAS_DEPTH) (overflow overwrites oldest, wraps). JR with count>0: ptr--, count--; JR at count=0: no change.
- BTB update (registered, next cycle visible): tag match & valid -> target overwritten, counter +1/-1 saturating at 2^DIRP_BITS-1 / 0. Miss -> allocate: valid=1, tag, target, counter = taken ? 2^(DIRP_BITS-1) : 2^(DIRP_BITS-1)-1. Same-cycle lookup at same index sees old contents.
- FQ: circular, FQ_DEPTH entries. Dequeue when valid & ready. Enqueue blocked when full even if dequeue same cycle (no bypass). Enqueue into empty queue: head visible next cycle (1-cycle I$-to-decode latency).
- Flush: take_resolved clears FQ (count=0, valid=0 next cycle), discards any enqueue/dequeue that cycle; RAS and BTB not restored; a same-cycle BTB update still applies.
- icache_REN/halt: next = core_control_halt ? (0,1) : (1,0), registered. Halt does not clear FQ; queued entries drain.
- Mid-operation reset: all state returns to reset values immediately (async).

Test Plan:
- Reset, 6 sequential non-branch hits, ready=1 -> icache_addr 0x0,0x4..0x14; valid rises 1 cycle after first hit; nPC=PC+1 each.
- ready=0, continuous hits, FQ_DEPTH=4 -> fq_count saturates 4, PC holds at 0x4 (word), no 5th enqueue; ready=1 one cycle -> count 3, next hit enqueues.
- JAL at PC 0x10 target 0x40, then JR at 0x40 -> nPCs 0x40 then 0x11; 5 JALs with RAS_DEPTH=4 then 5 JRs -> 4 correct returns, 5th predicts PC+1.
- Update PC 0x08 taken target 0x30 twice -> counter 2 then 3; BEQ fetched at 0x08 predicts 0x30; different tag same index (0x18) predicts 0x19.
- take_resolved=1, resolved_PC=0x100 with FQ holding 3 -> next cycle valid=0, fq_count=0, icache_addr=0x400.
- core_control_halt=1 -> next cycle icache_REN=0, icache_halt=1; PC frozen, FQ drains with ready=1.
